// File: rtl/efuse_ctrl_if.sv
// Command/response handshake between the system register block and efuse_ctrl.
// The master issues single-word read/program commands; the slave returns a one-cycle response.
interface efuse_ctrl_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int WORD_WIDTH = 1
) ();
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [WORD_WIDTH-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic [WORD_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/efuse_ctrl.sv
// eFuse array sequencer: preset->sense for reads, a held program pulse for writes.
// Every array pin comes straight from a flop; a RESP cycle separates consecutive operations.
module efuse_ctrl #(
    parameter int NWORDS        = 16,
    parameter int WORD_WIDTH    = 1,
    parameter int ADDR_WIDTH    = (NWORDS > 1) ? $clog2(NWORDS) : 1,
    parameter int PRESET_CYCLES = 1,
    parameter int SENSE_CYCLES  = 2,
    parameter int WRITE_CYCLES  = 100
) (
    input  logic                  clk,
    input  logic                  rst,
    efuse_ctrl_if.slave           bus,
    output logic [NWORDS-1:0]     BIT_SEL,
    output logic [WORD_WIDTH-1:0] COL_PROG_N,
    output logic                  PRESET_N,
    output logic                  SENSE,
    input  logic [WORD_WIDTH-1:0] OUT
);
    localparam int MAXC01 = (PRESET_CYCLES > SENSE_CYCLES) ? PRESET_CYCLES : SENSE_CYCLES;
    localparam int MAXC   = (MAXC01 > WRITE_CYCLES) ? MAXC01 : WRITE_CYCLES;
    localparam int CNT_W  = $clog2(MAXC + 1);

    localparam logic [CNT_W-1:0] P_LAST = CNT_W'(PRESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] S_LAST = CNT_W'(SENSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] W_LAST = CNT_W'(WRITE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [ADDR_WIDTH:0] NWORDS_W = (ADDR_WIDTH + 1)'(NWORDS);

    typedef enum logic [2:0] {S_IDLE, S_PRESET, S_SENSE, S_WRITE, S_RESP} state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  err_q, err_d;
    logic [WORD_WIDTH-1:0] rdata_q, rdata_d;
    logic [NWORDS-1:0]     bit_sel_q, bit_sel_d;
    logic [WORD_WIDTH-1:0] col_q, col_d;
    logic                  preset_n_q, preset_n_d;
    logic                  sense_q, sense_d;
    logic                  addr_oor;

    function automatic logic [NWORDS-1:0] onehot(input logic [ADDR_WIDTH-1:0] a);
        onehot    = '0;
        onehot[a] = 1'b1;
    endfunction

    assign addr_oor = {1'b0, bus.cmd_addr} >= NWORDS_W;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        err_d      = 1'b0;
        rdata_d    = rdata_q;
        bit_sel_d  = '0;
        col_d      = '1;
        preset_n_d = 1'b1;
        sense_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    addr_d = bus.cmd_addr;
                    if (addr_oor) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else if (bus.cmd_write) begin
                        // Nothing to blow: skip the array entirely.
                        if (|bus.cmd_wdata) begin
                            state_d   = S_WRITE;
                            cnt_d     = W_LAST;
                            bit_sel_d = onehot(bus.cmd_addr);
                            col_d     = ~bus.cmd_wdata;
                        end else begin
                            state_d = S_RESP;
                        end
                    end else begin
                        state_d    = S_PRESET;
                        cnt_d      = P_LAST;
                        preset_n_d = 1'b0;
                    end
                end
            end
            S_PRESET: begin
                if (cnt_q == '0) begin
                    state_d   = S_SENSE;
                    cnt_d     = S_LAST;
                    sense_d   = 1'b1;
                    bit_sel_d = onehot(addr_q);
                end else begin
                    cnt_d      = cnt_q - ONE;
                    preset_n_d = 1'b0;
                end
            end
            S_SENSE: begin
                // OUT is captured on the edge that drops SENSE.
                if (cnt_q == '0) begin
                    rdata_d = OUT;
                    state_d = S_RESP;
                end else begin
                    cnt_d     = cnt_q - ONE;
                    sense_d   = 1'b1;
                    bit_sel_d = bit_sel_q;
                end
            end
            S_WRITE: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d     = cnt_q - ONE;
                    bit_sel_d = bit_sel_q;
                    col_d     = col_q;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            bit_sel_q  <= '0;
            col_q      <= '1;
            preset_n_q <= 1'b1;
            sense_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            bit_sel_q  <= bit_sel_d;
            col_q      <= col_d;
            preset_n_q <= preset_n_d;
            sense_q    <= sense_d;
        end
    end

    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_err   = err_q;
    assign bus.rsp_rdata = rdata_q;
    assign BIT_SEL       = bit_sel_q;
    assign COL_PROG_N    = col_q;
    assign PRESET_N      = preset_n_q;
    assign SENSE         = sense_q;
endmodule

// File: tb/tb_efuse_ctrl.sv
// Directed bench for efuse_ctrl: a 16x1 instance (A) and a 12x8 instance (B), each with a
// behavioural fuse-array model that flags illegal pin states and only blows on a full pulse.
module tb_efuse_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int model_errs = 0;

    efuse_ctrl_if #(.ADDR_WIDTH(4), .WORD_WIDTH(1)) ifA ();
    efuse_ctrl_if #(.ADDR_WIDTH(4), .WORD_WIDTH(8)) ifB ();

    logic [15:0] bsA;  logic [0:0] colA, outA;  logic pnA, snA;
    logic [11:0] bsB;  logic [7:0] colB, outB;  logic pnB, snB;

    efuse_ctrl #(.NWORDS(16), .WORD_WIDTH(1)) dutA (
        .clk(clk), .rst(rst), .bus(ifA.slave),
        .BIT_SEL(bsA), .COL_PROG_N(colA), .PRESET_N(pnA), .SENSE(snA), .OUT(outA));

    efuse_ctrl #(.NWORDS(12), .WORD_WIDTH(8)) dutB (
        .clk(clk), .rst(rst), .bus(ifB.slave),
        .BIT_SEL(bsB), .COL_PROG_N(colB), .PRESET_N(pnB), .SENSE(snB), .OUT(outB));

    function automatic int oh_idx(input logic [15:0] v);
        oh_idx = 0;
        for (int i = 0; i < 16; i++) if (v[i]) oh_idx = i;
    endfunction

    // ---------------- array model A ----------------
    logic [0:0]  fuseA [16] = '{5: 1'b1, default: 1'b0};
    logic        preA = 1'b0, snA_p = 1'b0, prgA_p = 1'b0;
    int          pcA = 0;
    logic [0:0]  pcolA = '1;
    logic [15:0] pselA = '0;

    always_comb begin
        outA = '0;
        if (snA) outA = preA ? fuseA[oh_idx(bsA)] : ~fuseA[oh_idx(bsA)];
    end

    always @(posedge clk) begin
        if ($countones(bsA) > 1 || (snA && !pnA) || (colA != '1 && bsA == '0) ||
            (snA_p && !snA && (!pnA || colA != '1)) || (prgA_p && colA == '1 && (!pnA || snA)) ||
            (prgA_p && colA != '1 && (colA != pcolA || bsA != pselA))) begin
            model_errs <= model_errs + 1;
            $display("FAIL model_A illegal pins: bs=%h col=%b pn=%b sn=%b", bsA, colA, pnA, snA);
        end
        if (!pnA) preA <= 1'b1;
        else if (snA_p && !snA) preA <= 1'b0;
        snA_p  <= snA;
        prgA_p <= (colA != '1);
        if (colA != '1) begin
            pcA <= pcA + 1; pcolA <= colA; pselA <= bsA;
        end else if (pcA > 0) begin
            if (pcA >= 100) fuseA[oh_idx(pselA)] <= fuseA[oh_idx(pselA)] | ~pcolA;
            pcA <= 0;
        end
    end

    // ---------------- array model B ----------------
    logic [7:0]  fuseB [12] = '{default: 8'h00};
    logic        preB = 1'b0, snB_p = 1'b0, prgB_p = 1'b0;
    int          pcB = 0;
    logic [7:0]  pcolB = '1;
    logic [11:0] pselB = '0;

    always_comb begin
        outB = '0;
        if (snB) outB = preB ? fuseB[oh_idx({4'b0, bsB})] : ~fuseB[oh_idx({4'b0, bsB})];
    end

    always @(posedge clk) begin
        if ($countones(bsB) > 1 || (snB && !pnB) || (colB != '1 && bsB == '0) ||
            (snB_p && !snB && (!pnB || colB != '1)) || (prgB_p && colB == '1 && (!pnB || snB)) ||
            (prgB_p && colB != '1 && (colB != pcolB || bsB != pselB))) begin
            model_errs <= model_errs + 1;
            $display("FAIL model_B illegal pins: bs=%h col=%h pn=%b sn=%b", bsB, colB, pnB, snB);
        end
        if (!pnB) preB <= 1'b1;
        else if (snB_p && !snB) preB <= 1'b0;
        snB_p  <= snB;
        prgB_p <= (colB != '1);
        if (colB != '1) begin
            pcB <= pcB + 1; pcolB <= colB; pselB <= bsB;
        end else if (pcB > 0) begin
            if (pcB >= 100) fuseB[oh_idx({4'b0, pselB})] <= fuseB[oh_idx({4'b0, pselB})] | ~pcolB;
            pcB <= 0;
        end
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic rd_a(input logic [3:0] a, output logic [0:0] d, output bit ok);
        d = '0; ok = 1'b0;
        @(negedge clk); ifA.cmd_valid = 1'b1; ifA.cmd_write = 1'b0; ifA.cmd_addr = a;
        @(negedge clk); ifA.cmd_valid = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (ifA.rsp_valid) begin ok = 1'b1; d = ifA.rsp_rdata; end
            else @(negedge clk);
        end
    endtask

    task automatic rd_b(input logic [3:0] a, output logic [7:0] d, output bit ok);
        d = '0; ok = 1'b0;
        @(negedge clk); ifB.cmd_valid = 1'b1; ifB.cmd_write = 1'b0; ifB.cmd_addr = a;
        @(negedge clk); ifB.cmd_valid = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (ifB.rsp_valid) begin ok = 1'b1; d = ifB.rsp_rdata; end
            else @(negedge clk);
        end
    endtask

    // Program on B; counts pulse cycles whose pins match exp_col/exp_sel, and the rsp offset.
    task automatic wr_b(input logic [3:0] a, input logic [7:0] wd, input logic [7:0] exp_col,
                        input logic [11:0] exp_sel, output int good, output int bad, output int at);
        good = 0; bad = 0; at = -1;
        @(negedge clk); ifB.cmd_valid = 1'b1; ifB.cmd_write = 1'b1; ifB.cmd_addr = a; ifB.cmd_wdata = wd;
        @(negedge clk); ifB.cmd_valid = 1'b0;
        for (int n = 0; n < 150 && at < 0; n++) begin
            if (ifB.rsp_valid) at = n;
            else begin
                if (colB == exp_col && bsB == exp_sel) good++; else bad++;
                @(negedge clk);
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        vectors++; if (ifA.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready_A got=%b exp=1", ifA.cmd_ready); end
        vectors++; if (ifA.rsp_valid !== 1'b0 || ifA.rsp_err !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_A got v=%b e=%b exp 0/0", ifA.rsp_valid, ifA.rsp_err); end
        vectors++; if (ifA.rsp_rdata !== 1'b0) begin miscompares++; $display("FAIL reset_rdata_A got=%b exp=0", ifA.rsp_rdata); end
        vectors++; if ({bsA, colA, pnA, snA} !== {16'h0, 1'b1, 1'b1, 1'b0}) begin miscompares++; $display("FAIL reset_pins_A got bs=%h col=%b pn=%b sn=%b exp 0000/1/1/0", bsA, colA, pnA, snA); end
        vectors++; if ({bsB, colB, pnB, snB} !== {12'h0, 8'hFF, 1'b1, 1'b0} || ifB.rsp_rdata !== 8'h00 || ifB.cmd_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset_B got bs=%h col=%h pn=%b sn=%b rd=%h rdy=%b", bsB, colB, pnB, snB, ifB.rsp_rdata, ifB.cmd_ready); end
    endtask

    task automatic test_read;
        @(negedge clk); ifA.cmd_valid = 1'b1; ifA.cmd_write = 1'b0; ifA.cmd_addr = 4'd5;
        @(negedge clk); ifA.cmd_valid = 1'b0;   // cycle E
        vectors++; if ({pnA, snA, bsA} !== {1'b0, 1'b0, 16'h0}) begin miscompares++; $display("FAIL read_preset got pn=%b sn=%b bs=%h exp 0/0/0000", pnA, snA, bsA); end
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            vectors++; if ({pnA, snA, bsA} !== {1'b1, 1'b1, 16'h0020}) begin miscompares++; $display("FAIL read_sense%0d got pn=%b sn=%b bs=%h exp 1/1/0020", k, pnA, snA, bsA); end
        end
        @(negedge clk);                          // cycle E+3
        vectors++; if ({ifA.rsp_valid, ifA.rsp_rdata, ifA.rsp_err, ifA.cmd_ready} !== 4'b1100) begin
            miscompares++; $display("FAIL read_rsp got v=%b d=%b e=%b rdy=%b exp 1/1/0/0", ifA.rsp_valid, ifA.rsp_rdata, ifA.rsp_err, ifA.cmd_ready); end
        vectors++; if ({pnA, snA, bsA} !== {1'b1, 1'b0, 16'h0}) begin miscompares++; $display("FAIL read_rsp_pins got pn=%b sn=%b bs=%h exp idle", pnA, snA, bsA); end
        @(negedge clk);
        vectors++; if ({ifA.rsp_valid, ifA.cmd_ready} !== 2'b01) begin miscompares++; $display("FAIL read_ready_again got v=%b rdy=%b exp 0/1", ifA.rsp_valid, ifA.cmd_ready); end
    endtask

    task automatic test_reset_mid_read;
        logic [0:0] d; bit ok; int seen;
        @(negedge clk); ifA.cmd_valid = 1'b1; ifA.cmd_write = 1'b0; ifA.cmd_addr = 4'd5;
        @(negedge clk); ifA.cmd_valid = 1'b0;
        @(negedge clk);
        vectors++; if (snA !== 1'b1) begin miscompares++; $display("FAIL midrst_in_sense got sn=%b exp 1", snA); end
        #1 rst = 1'b1;
        #1;
        vectors++; if ({bsA, pnA, snA, ifA.cmd_ready} !== {16'h0, 1'b1, 1'b0, 1'b1}) begin
            miscompares++; $display("FAIL midrst_idle got bs=%h pn=%b sn=%b rdy=%b exp 0000/1/0/1", bsA, pnA, snA, ifA.cmd_ready); end
        @(negedge clk); rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin @(negedge clk); if (ifA.rsp_valid) seen++; end
        vectors++; if (seen !== 0) begin miscompares++; $display("FAIL midrst_no_rsp got %0d rsp pulses exp 0", seen); end
        rd_a(4'd5, d, ok);
        vectors++; if (!ok || d !== 1'b1) begin miscompares++; $display("FAIL midrst_reread got ok=%b d=%b exp 1/1", ok, d); end
    endtask

    task automatic test_program;
        int good, bad, at; logic [0:0] d; bit ok;
        good = 0; bad = 0; at = -1;
        @(negedge clk); ifA.cmd_valid = 1'b1; ifA.cmd_write = 1'b1; ifA.cmd_addr = 4'd3; ifA.cmd_wdata = 1'b1;
        @(negedge clk); ifA.cmd_valid = 1'b0;
        for (int n = 0; n < 150 && at < 0; n++) begin
            if (ifA.rsp_valid) at = n;
            else begin
                if (colA == 1'b0 && bsA == 16'h0008) good++; else bad++;
                @(negedge clk);
            end
        end
        vectors++; if (good !== 100 || bad !== 0) begin miscompares++; $display("FAIL prog_pulse got good=%0d bad=%0d exp 100/0", good, bad); end
        vectors++; if (at !== 100 || ifA.rsp_err !== 1'b0) begin miscompares++; $display("FAIL prog_rsp got at=%0d err=%b exp 100/0", at, ifA.rsp_err); end
        vectors++; if ({bsA, colA} !== {16'h0, 1'b1}) begin miscompares++; $display("FAIL prog_exit_pins got bs=%h col=%b exp idle", bsA, colA); end
        rd_a(4'd3, d, ok);
        vectors++; if (!ok || d !== 1'b1) begin miscompares++; $display("FAIL prog_readback3 got ok=%b d=%b exp 1/1", ok, d); end
        rd_a(4'd4, d, ok);
        vectors++; if (!ok || d !== 1'b0) begin miscompares++; $display("FAIL prog_read4 got ok=%b d=%b exp 1/0", ok, d); end
    endtask

    task automatic test_wide;
        int good, bad, at; logic [7:0] d; bit ok;
        wr_b(4'd0, 8'hA5, 8'h5A, 12'h001, good, bad, at);
        vectors++; if (good !== 100 || bad !== 0 || at !== 100) begin miscompares++; $display("FAIL wide_a5 got good=%0d bad=%0d at=%0d exp 100/0/100", good, bad, at); end
        wr_b(4'd0, 8'h0F, 8'hF0, 12'h001, good, bad, at);
        vectors++; if (good !== 100 || bad !== 0 || at !== 100) begin miscompares++; $display("FAIL wide_0f got good=%0d bad=%0d at=%0d exp 100/0/100", good, bad, at); end
        rd_b(4'd0, d, ok);
        vectors++; if (!ok || d !== 8'hAF) begin miscompares++; $display("FAIL wide_readback got ok=%b d=%h exp 1/af", ok, d); end
    endtask

    task automatic test_zero_err;
        @(negedge clk); ifB.cmd_valid = 1'b1; ifB.cmd_write = 1'b1; ifB.cmd_addr = 4'd2; ifB.cmd_wdata = 8'h00;
        @(negedge clk); ifB.cmd_valid = 1'b0;
        vectors++; if ({ifB.rsp_valid, ifB.rsp_err} !== 2'b10) begin miscompares++; $display("FAIL zero_rsp got v=%b e=%b exp 1/0", ifB.rsp_valid, ifB.rsp_err); end
        vectors++; if ({bsB, colB, pnB, snB} !== {12'h0, 8'hFF, 1'b1, 1'b0}) begin miscompares++; $display("FAIL zero_pins got bs=%h col=%h pn=%b sn=%b exp idle", bsB, colB, pnB, snB); end
        @(negedge clk);
        vectors++; if ({ifB.rsp_valid, ifB.cmd_ready} !== 2'b01) begin miscompares++; $display("FAIL zero_after got v=%b rdy=%b exp 0/1", ifB.rsp_valid, ifB.cmd_ready); end
        ifB.cmd_valid = 1'b1; ifB.cmd_write = 1'b0; ifB.cmd_addr = 4'd12;
        @(negedge clk); ifB.cmd_valid = 1'b0;
        vectors++; if ({ifB.rsp_valid, ifB.rsp_err} !== 2'b11) begin miscompares++; $display("FAIL err_rsp got v=%b e=%b exp 1/1", ifB.rsp_valid, ifB.rsp_err); end
        vectors++; if (ifB.rsp_rdata !== 8'hAF) begin miscompares++; $display("FAIL err_rdata_kept got %h exp af", ifB.rsp_rdata); end
        vectors++; if ({bsB, colB, pnB, snB} !== {12'h0, 8'hFF, 1'b1, 1'b0}) begin miscompares++; $display("FAIL err_pins got bs=%h col=%h pn=%b sn=%b exp idle", bsB, colB, pnB, snB); end
        @(negedge clk);
        vectors++; if ({ifB.rsp_valid, ifB.rsp_err, ifB.cmd_ready} !== 3'b001) begin miscompares++; $display("FAIL err_after got v=%b e=%b rdy=%b exp 0/0/1", ifB.rsp_valid, ifB.rsp_err, ifB.cmd_ready); end
    endtask

    task automatic test_back_to_back;
        logic [3:0] addrs [3];
        logic [0:0] exp_d [3];
        logic [0:0] d; bit got; int busy_ready;
        addrs = '{4'd5, 4'd3, 4'd4};
        exp_d = '{1'b1, 1'b1, 1'b0};
        @(negedge clk); ifA.cmd_valid = 1'b1; ifA.cmd_write = 1'b0; ifA.cmd_addr = addrs[0];
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            ifA.cmd_addr = (k < 2) ? addrs[k+1] : 4'd0;
            got = 1'b0; busy_ready = 0; d = '0;
            for (int i = 0; i < 10 && !got; i++) begin
                if (ifA.cmd_ready) busy_ready++;
                if (ifA.rsp_valid) begin got = 1'b1; d = ifA.rsp_rdata; end
                else @(negedge clk);
            end
            vectors++; if (!got || busy_ready !== 0 || d !== exp_d[k]) begin
                miscompares++; $display("FAIL b2b_read%0d got ok=%b busy_ready=%0d d=%b exp 1/0/%b", k, got, busy_ready, d, exp_d[k]); end
            @(negedge clk);
            vectors++; if (ifA.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_gap%0d got rdy=%b exp 1", k, ifA.cmd_ready); end
            if (k == 2) ifA.cmd_valid = 1'b0;
        end
    endtask

    task automatic test_model;
        repeat (3) @(negedge clk);
        vectors++; if (model_errs !== 0) begin miscompares++; $display("FAIL array_model got %0d violations exp 0", model_errs); end
    endtask

    initial begin
        rst = 1'b1;
        ifA.cmd_valid = 1'b0; ifA.cmd_write = 1'b0; ifA.cmd_addr = '0; ifA.cmd_wdata = '0;
        ifB.cmd_valid = 1'b0; ifB.cmd_write = 1'b0; ifB.cmd_addr = '0; ifB.cmd_wdata = '0;
        repeat (2) @(negedge clk);
        test_reset;
        rst = 1'b0;
        test_read;
        test_reset_mid_read;
        test_program;
        test_wide;
        test_zero_err;
        test_back_to_back;
        test_model;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
